// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a GRN node array: drives the shared node control bus
// and reads s0/s1 back to report the attractor period (lambda) and transient length (mu).
module gnr_attractor_ctrl #(
   parameter int NUM_NODES = 8,
   parameter int CNT_WIDTH = 16,
   parameter int MAX_STEPS = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_NODES-1:0] init_value,
   output logic                 reset_nos,
   output logic [NUM_NODES-1:0] init_state,
   output logic                 start_s0,
   output logic                 start_s1,
   input  logic [NUM_NODES-1:0] s0_vec,
   input  logic [NUM_NODES-1:0] s1_vec,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] transient
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_STEPS);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_MEET_P, S_MEET_W, S_LAM_P, S_LAM_W, S_RST2,
      S_ADV_P, S_ADV_W, S_MU_W, S_MU_A, S_MU_B, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   step_cnt_q, step_cnt_d;
   logic [CNT_WIDTH-1:0]   adv_cnt_q, adv_cnt_d;
   logic [CNT_WIDTH-1:0]   mu_cnt_q, mu_cnt_d;
   logic [NUM_NODES-1:0]   meet_q, meet_d;
   logic [NUM_NODES-1:0]   init_state_q, init_state_d;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [CNT_WIDTH-1:0]   transient_q, transient_d;
   logic                   timeout_q, timeout_d;
   logic                   reset_nos_q, reset_nos_d;
   logic                   start_s0_q, start_s0_d;
   logic                   start_s1_q, start_s1_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d      = state_q;
      step_cnt_d   = step_cnt_q;
      adv_cnt_d    = adv_cnt_q;
      mu_cnt_d     = mu_cnt_q;
      meet_d       = meet_q;
      init_state_d = init_state_q;
      period_d     = period_q;
      transient_d  = transient_q;
      timeout_d    = timeout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               init_state_d = init_value;
               period_d     = '0;
               transient_d  = '0;
               timeout_d    = 1'b0;
               state_d      = S_INIT;
            end
         end
         S_INIT: begin
            step_cnt_d = '0;
            state_d    = S_MEET_P;
         end
         S_MEET_P: begin
            step_cnt_d = step_cnt_q + ONE;
            state_d    = S_MEET_W;
         end
         // Odd pulse counts leave s0 one half-step behind, so only even counts are real x_k vs x_2k compares.
         S_MEET_W: begin
            if (!step_cnt_q[0] && (step_cnt_q >= TWO) && (s0_vec == s1_vec)) begin
               meet_d     = s1_vec;
               step_cnt_d = '0;
               state_d    = S_LAM_P;
            end else if (step_cnt_q >= MAX_CNT) begin
               timeout_d   = 1'b1;
               period_d    = '0;
               transient_d = '0;
               state_d     = S_DONE;
            end else begin
               state_d = S_MEET_P;
            end
         end
         S_LAM_P: begin
            step_cnt_d = step_cnt_q + ONE;
            state_d    = S_LAM_W;
         end
         S_LAM_W: begin
            if (s1_vec == meet_q) begin
               period_d = step_cnt_q;
               state_d  = S_RST2;
            end else if (step_cnt_q >= MAX_CNT) begin
               timeout_d   = 1'b1;
               period_d    = '0;
               transient_d = '0;
               state_d     = S_DONE;
            end else begin
               state_d = S_LAM_P;
            end
         end
         S_RST2: begin
            adv_cnt_d = '0;
            state_d   = S_ADV_P;
         end
         S_ADV_P: begin
            adv_cnt_d = adv_cnt_q + ONE;
            state_d   = S_ADV_W;
         end
         S_ADV_W: begin
            if (adv_cnt_q == period_q) begin
               mu_cnt_d = '0;
               state_d  = S_MU_W;
            end else begin
               state_d = S_ADV_P;
            end
         end
         // Hare now leads the tortoise by lambda; they first agree at index mu.
         S_MU_W: begin
            if (s0_vec == s1_vec) begin
               transient_d = mu_cnt_q;
               state_d     = S_DONE;
            end else if (mu_cnt_q >= MAX_CNT) begin
               timeout_d   = 1'b1;
               period_d    = '0;
               transient_d = '0;
               state_d     = S_DONE;
            end else begin
               state_d = S_MU_A;
            end
         end
         S_MU_A: state_d = S_MU_B;
         S_MU_B: begin
            mu_cnt_d = mu_cnt_q + ONE;
            state_d  = S_MU_W;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered pulse lines up with the state.
      reset_nos_d = (state_d == S_INIT) || (state_d == S_RST2);
      start_s0_d  = (state_d == S_MEET_P) || (state_d == S_MU_A) || (state_d == S_MU_B);
      start_s1_d  = (state_d == S_MEET_P) || (state_d == S_LAM_P) ||
                    (state_d == S_ADV_P)  || (state_d == S_MU_A);
      busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         step_cnt_q   <= '0;
         adv_cnt_q    <= '0;
         mu_cnt_q     <= '0;
         meet_q       <= '0;
         init_state_q <= '0;
         period_q     <= '0;
         transient_q  <= '0;
         timeout_q    <= 1'b0;
         reset_nos_q  <= 1'b0;
         start_s0_q   <= 1'b0;
         start_s1_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         adv_cnt_q    <= adv_cnt_d;
         mu_cnt_q     <= mu_cnt_d;
         meet_q       <= meet_d;
         init_state_q <= init_state_d;
         period_q     <= period_d;
         transient_q  <= transient_d;
         timeout_q    <= timeout_d;
         reset_nos_q  <= reset_nos_d;
         start_s0_q   <= start_s0_d;
         start_s1_q   <= start_s1_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign reset_nos  = reset_nos_q;
   assign init_state = init_state_q;
   assign start_s0   = start_s0_q;
   assign start_s1   = start_s1_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign period     = period_q;
   assign transient  = transient_q;

endmodule
